// File: rtl/outer_loop_seq_if.sv
// Control/status bundle between the outer-loop sequencer and its user.
// The slave side is the sequencer; the master side drives the controls.
interface outer_loop_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             LD;
    logic [WIDTH-1:0] DIN;
    logic             GO;
    logic             STOP;
    logic             INNER_DONE;
    logic             INNER_START;
    logic [WIDTH-1:0] CNT;
    logic             BUSY;
    logic             DONE;

    modport slave (
        input  LD, DIN, GO, STOP, INNER_DONE,
        output INNER_START, CNT, BUSY, DONE
    );

    modport master (
        output LD, DIN, GO, STOP, INNER_DONE,
        input  INNER_START, CNT, BUSY, DONE
    );
endinterface

// File: rtl/outer_loop_seq.sv
// Outer-loop sequencer for the blitter: holds a loadable iteration count,
// launches one inner pass per iteration and pulses DONE at terminal count.
// A loaded count of 0 runs 2^WIDTH iterations.
module outer_loop_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               MasterClock,
    input  logic               RESET,
    outer_loop_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_STEP
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic             done_r, done_nxt;

    // State, count and DONE registers
    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) begin
            state  <= S_IDLE;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_r <= done_nxt;
        end
    end

    // Next-state, count and DONE decode; STOP outranks every busy transition
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.LD) begin
                    cnt_nxt = bus.DIN;
                end else if (bus.GO) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_nxt = bus.STOP ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (bus.STOP) begin
                    state_nxt = S_IDLE;
                end else if (bus.INNER_DONE) begin
                    state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                if (bus.STOP) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - WIDTH'(1);
                    if (cnt == WIDTH'(1)) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_LAUNCH;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state
    always_comb begin
        bus.INNER_START = (state == S_LAUNCH);
        bus.BUSY        = (state != S_IDLE);
        bus.DONE        = done_r;
        bus.CNT         = cnt;
    end

endmodule

// File: tb/tb_outer_loop_seq.sv
// Self-checking bench for outer_loop_seq: the bench plays the inner-loop
// engine with randomized response delays and checks a cycle timeline
// derived from the iteration count and handshake latencies.
module tb_outer_loop_seq;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    outer_loop_seq_if #(.WIDTH(W)) bus ();

    outer_loop_seq #(.WIDTH(W)) dut (
        .MasterClock (clk),
        .RESET       (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v);
        bus.LD  = 1'b1;
        bus.DIN = v;
        tick();
        bus.LD  = 1'b0;
        chk("load_cnt", 32'(bus.CNT), 32'(v));
        chk("load_idle", 32'(bus.BUSY), 0);
    endtask

    // Start a run from the current count. kfix=0 picks a random inner delay
    // per iteration; stop_iter>=0 aborts during that iteration's WAIT;
    // disturb pulses LD/GO/INNER_DONE in every LAUNCH cycle.
    task automatic run(input int startcnt, input int kfix, input int stop_iter, input bit disturb);
        int n;
        int k;
        int exp_cnt;
        n = (startcnt == 0) ? (1 << W) : startcnt;
        bus.GO = 1'b1;
        tick();
        bus.GO = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_cnt = (startcnt - i) & ((1 << W) - 1);
            k = (kfix == 0) ? int'($urandom_range(1, 4)) : kfix;
            chk("launch_pulse", 32'(bus.INNER_START), 1);
            chk("launch_busy", 32'(bus.BUSY), 1);
            chk("launch_cnt", 32'(bus.CNT), 32'(exp_cnt));
            if (disturb) begin
                bus.LD = 1'b1; bus.DIN = 8'd9; bus.GO = 1'b1; bus.INNER_DONE = 1'b1;
            end
            tick();
            bus.LD = 1'b0; bus.GO = 1'b0; bus.INNER_DONE = 1'b0;
            if (i == stop_iter) begin
                bus.STOP = 1'b1;
                tick();
                bus.STOP = 1'b0;
                chk("stop_busy", 32'(bus.BUSY), 0);
                chk("stop_cnt", 32'(bus.CNT), 32'(exp_cnt));
                chk("stop_done", 32'(bus.DONE), 0);
                chk("stop_start", 32'(bus.INNER_START), 0);
                tick();
                chk("stop_done2", 32'(bus.DONE), 0);
                chk("stop_busy2", 32'(bus.BUSY), 0);
                return;
            end
            for (int j = 1; j < k; j++) begin
                chk("wait_nostart", 32'(bus.INNER_START), 0);
                chk("wait_busy", 32'(bus.BUSY), 1);
                chk("wait_cnt", 32'(bus.CNT), 32'(exp_cnt));
                tick();
            end
            bus.INNER_DONE = 1'b1;
            tick();
            bus.INNER_DONE = 1'b0;
            chk("step_nostart", 32'(bus.INNER_START), 0);
            chk("step_busy", 32'(bus.BUSY), 1);
            chk("step_nodone", 32'(bus.DONE), 0);
            tick();
        end
        chk("end_done", 32'(bus.DONE), 1);
        chk("end_busy", 32'(bus.BUSY), 0);
        chk("end_cnt", 32'(bus.CNT), 0);
        chk("end_nostart", 32'(bus.INNER_START), 0);
        tick();
        chk("end_done_once", 32'(bus.DONE), 0);
        chk("end_no_extra", 32'(bus.INNER_START), 0);
        chk("end_idle", 32'(bus.BUSY), 0);
    endtask

    initial begin
        int v;
        total = 0;
        bad   = 0;
        rst = 1'b1;
        bus.LD = 1'b0; bus.DIN = '0; bus.GO = 1'b0;
        bus.STOP = 1'b0; bus.INNER_DONE = 1'b0;
        #12;
        chk("rst_cnt", 32'(bus.CNT), 0);
        chk("rst_busy", 32'(bus.BUSY), 0);
        chk("rst_start", 32'(bus.INNER_START), 0);
        chk("rst_done", 32'(bus.DONE), 0);
        rst = 1'b0;
        tick();

        // three iterations, inner engine answers two cycles after start
        load(8'd3);
        run(3, 2, -1, 1'b0);

        // zero count runs the full 2^WIDTH iterations
        load(8'd0);
        run(0, 1, -1, 1'b0);

        // abort in the second WAIT, then resume from the held count
        load(8'd5);
        run(5, 2, 1, 1'b0);
        chk("resume_cnt", 32'(bus.CNT), 4);
        run(4, 0, -1, 1'b0);

        // LD/GO/INNER_DONE while busy must not disturb the run
        load(8'd2);
        run(2, 3, -1, 1'b1);

        // LD wins over GO in the same IDLE cycle
        bus.LD = 1'b1; bus.DIN = 8'd7; bus.GO = 1'b1;
        tick();
        bus.LD = 1'b0; bus.GO = 1'b0;
        chk("ldgo_cnt", 32'(bus.CNT), 7);
        chk("ldgo_busy", 32'(bus.BUSY), 0);
        chk("ldgo_start", 32'(bus.INNER_START), 0);
        run(7, 0, -1, 1'b0);

        // STOP in IDLE does not block a load
        bus.STOP = 1'b1; bus.LD = 1'b1; bus.DIN = 8'd4;
        tick();
        bus.STOP = 1'b0; bus.LD = 1'b0;
        chk("idle_stop_ld", 32'(bus.CNT), 4);
        chk("idle_stop_busy", 32'(bus.BUSY), 0);

        // randomized counts and inner delays
        for (int r = 0; r < 6; r++) begin
            v = int'($urandom_range(1, 12));
            load(8'(v));
            run(v, 0, -1, 1'b0);
        end

        // asynchronous reset during WAIT
        load(8'd6);
        bus.GO = 1'b1;
        tick();
        bus.GO = 1'b0;
        tick();
        chk("pre_rst_busy", 32'(bus.BUSY), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.BUSY), 0);
        chk("arst_cnt", 32'(bus.CNT), 0);
        chk("arst_start", 32'(bus.INNER_START), 0);
        chk("arst_done", 32'(bus.DONE), 0);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.INNER_DONE = 1'b1;
            tick();
            bus.INNER_DONE = 1'b0;
            chk("post_rst_busy", 32'(bus.BUSY), 0);
            chk("post_rst_start", 32'(bus.INNER_START), 0);
            chk("post_rst_done", 32'(bus.DONE), 0);
            chk("post_rst_cnt", 32'(bus.CNT), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
